// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan/debounce controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } state_e;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
    localparam int unsigned COL_W    = $clog2(NUM_COLS);

    localparam logic [NUM_COLS-1:0] COL_IDLE_N = 4'b1110;

    // Column index to one-hot active-low drive pattern.
    function automatic logic [NUM_COLS-1:0] col_drive_n(input logic [COL_W-1:0] col);
        return ~(NUM_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Free-running scan divider: one-cycle tick every SCAN_DIV clocks.
module keypad_scan_timer #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered so it lines up with the wrap of the counter.
    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(SCAN_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_W'(SCAN_DIV - 2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce.
// Optional auto-repeat strobes when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
`endif

    logic                tick;
    logic [NUM_ROWS-1:0] row_m_q, row_s_q;
    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [ROW_W-1:0]    cand_q, cand_d;
    logic [DEB_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_pressed_q, key_pressed_d;
    logic                any_low;
    logic [ROW_W-1:0]    low_idx;
`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0]    rep_q, rep_d;
`endif

    keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Lowest-index low row wins when several rows are active.
    always_comb begin
        any_low = ~&row_s_q;
        low_idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!row_s_q[i]) low_idx = ROW_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d         = rep_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cand_d = low_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            key_code_d    = {low_idx, col_q};
                            key_valid_d   = 1'b1;
                            key_pressed_d = 1'b1;
                            cnt_d         = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_d         = '0;
`endif
                            state_d       = HELD;
                        end else begin
                            cnt_d   = DEB_W'(1);
                            state_d = CONFIRM;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                CONFIRM: begin
                    if (any_low && (low_idx == cand_q)) begin
                        if (cnt_q + DEB_W'(1) == DEB_W'(DEBOUNCE_TICKS)) begin
                            key_code_d    = {cand_q, col_q};
                            key_valid_d   = 1'b1;
                            key_pressed_d = 1'b1;
                            cnt_d         = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_d         = '0;
`endif
                            state_d       = HELD;
                        end else begin
                            cnt_d = cnt_q + DEB_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + COL_W'(1);
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (row_s_q[cand_q]) begin
                        if (cnt_q + DEB_W'(1) == DEB_W'(DEBOUNCE_TICKS)) begin
                            key_pressed_d = 1'b0;
                            cnt_d         = '0;
                            col_d         = col_q + COL_W'(1);
                            state_d       = SCAN;
                        end else begin
                            cnt_d = cnt_q + DEB_W'(1);
                        end
`ifdef KEYPAD_REPEAT_EN
                        rep_d = '0;
`endif
                    end else begin
                        cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        // A bounce in the release count restarts the repeat interval.
                        if (cnt_q != '0) begin
                            rep_d = '0;
                        end else if (rep_q + REP_W'(1) == REP_W'(REPEAT_TICKS)) begin
                            rep_d       = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
        col_n_d = col_drive_n(col_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m_q       <= '1;
            row_s_q       <= '1;
            state_q       <= SCAN;
            col_q         <= '0;
            col_n_q       <= COL_IDLE_N;
            cand_q        <= '0;
            cnt_q         <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            row_m_q       <= row_n;
            row_s_q       <= row_m_q;
            state_q       <= state_d;
            col_q         <= col_d;
            col_n_q       <= col_n_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign col_n       = col_n_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a key-matrix model on row_n.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned REP      = 5;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys;
    logic [3:0]  glitch_low;
    int          n_checks;
    int          n_fail;

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        logic [3:0] r_n;
        r_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) r_n[r] = 1'b0;
            end
        end
        row_n = r_n & ~glitch_low;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        keys       = '0;
        glitch_low = '0;
        repeat (3) step();
        n_checks++;
        if (col_n !== 4'b1110) begin n_fail++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
        n_checks++;
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_checks++;
        if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_key_pressed: got %b expected 0", key_pressed); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Edge i after reset release: column index (i/4)%4.
    task automatic test_idle_scan;
        logic [3:0] one;
        logic [3:0] exp;
        one = 4'b0001;
        for (int i = 1; i <= 40; i++) begin
            step();
            exp = ~(one << ((i / 4) % 4));
            n_checks++;
            if (col_n !== exp) begin n_fail++; $display("FAIL idle_col_n edge %0d: got %b expected %b", i, col_n, exp); end
            n_checks++;
            if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_key_valid edge %0d: got %b expected 0", i, key_valid); end
        end
    endtask

    // Key row2/col1: column 1 driven at edge 52, accepted on tick at edge 64.
    task automatic test_press;
        int strobes;
        int strobe_at;
        strobes   = 0;
        strobe_at = -1;
        keys = 16'h0200;
        for (int i = 41; i <= 72; i++) begin
            step();
            if (key_valid === 1'b1) begin strobes++; strobe_at = i; end
            if (i == 63) begin
                n_checks++;
                if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL press_early_pressed: got %b expected 0", key_pressed); end
            end
        end
        n_checks++;
        if (strobes != 1) begin n_fail++; $display("FAIL press_strobe_count: got %0d expected 1", strobes); end
        n_checks++;
        if (strobe_at != 64) begin n_fail++; $display("FAIL press_strobe_edge: got %0d expected 64", strobe_at); end
        n_checks++;
        if (key_code !== 4'h9) begin n_fail++; $display("FAIL press_key_code: got %h expected 9", key_code); end
        n_checks++;
        if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL press_key_pressed: got %b expected 1", key_pressed); end
        n_checks++;
        if (col_n !== 4'b1101) begin n_fail++; $display("FAIL press_col_frozen: got %b expected 1101", col_n); end
        keys = '0;
        for (int i = 73; i <= 84; i++) begin
            step();
            if (i == 83) begin
                n_checks++;
                if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL release_early: got %b expected 1", key_pressed); end
            end
        end
        n_checks++;
        if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL release_pressed: got %b expected 0", key_pressed); end
        n_checks++;
        if (key_code !== 4'h9) begin n_fail++; $display("FAIL release_code_held: got %h expected 9", key_code); end
        n_checks++;
        if (col_n !== 4'b1011) begin n_fail++; $display("FAIL release_col_advance: got %b expected 1011", col_n); end
    endtask

    // Row 0 low for a single tick (edge 88) while column 2 is driven.
    task automatic test_glitch;
        int strobes;
        strobes    = 0;
        glitch_low = 4'b0001;
        for (int i = 85; i <= 96; i++) begin
            step();
            if (i == 86) glitch_low = '0;
            if (key_valid === 1'b1) strobes++;
            if (i == 88) begin
                n_checks++;
                if (col_n !== 4'b1011) begin n_fail++; $display("FAIL glitch_col_frozen: got %b expected 1011", col_n); end
            end
            if (i == 92) begin
                n_checks++;
                if (col_n !== 4'b0111) begin n_fail++; $display("FAIL glitch_col_resume: got %b expected 0111", col_n); end
            end
        end
        n_checks++;
        if (strobes != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", strobes); end
        n_checks++;
        if (col_n !== 4'b1110) begin n_fail++; $display("FAIL glitch_col_wrap: got %b expected 1110", col_n); end
        n_checks++;
        if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL glitch_pressed: got %b expected 0", key_pressed); end
    endtask

    // Rows 1 and 3 on column 2: column driven at edge 104, accept at 116.
    task automatic test_multi_row;
        int strobes;
        int strobe_at;
        strobes   = 0;
        strobe_at = -1;
        keys = 16'h4040;
        for (int i = 97; i <= 120; i++) begin
            step();
            if (key_valid === 1'b1) begin strobes++; strobe_at = i; end
        end
        n_checks++;
        if (strobes != 1) begin n_fail++; $display("FAIL multi_strobe_count: got %0d expected 1", strobes); end
        n_checks++;
        if (strobe_at != 116) begin n_fail++; $display("FAIL multi_strobe_edge: got %0d expected 116", strobe_at); end
        n_checks++;
        if (key_code !== 4'h6) begin n_fail++; $display("FAIL multi_key_code: got %h expected 6", key_code); end
        keys = '0;
        for (int i = 121; i <= 132; i++) begin
            step();
            if (i == 131) begin
                n_checks++;
                if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL multi_release_early: got %b expected 1", key_pressed); end
            end
        end
        n_checks++;
        if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL multi_release: got %b expected 0", key_pressed); end
        n_checks++;
        if (key_code !== 4'h6) begin n_fail++; $display("FAIL multi_code_held: got %h expected 6", key_code); end
        n_checks++;
        if (col_n !== 4'b0111) begin n_fail++; $display("FAIL multi_col_advance: got %b expected 0111", col_n); end
    endtask

    task automatic test_reset_in_held;
        bit seen;
        seen = 1'b0;
        keys = 16'h0020;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (key_pressed === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL held_timeout: got no press expected key_pressed=1"); end
        n_checks++;
        if (key_code !== 4'h5) begin n_fail++; $display("FAIL held_key_code: got %h expected 5", key_code); end
        repeat (2) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (col_n !== 4'b1110) begin n_fail++; $display("FAIL rst_held_col_n: got %b expected 1110", col_n); end
        n_checks++;
        if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL rst_held_pressed: got %b expected 0", key_pressed); end
        n_checks++;
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_held_code: got %h expected 0", key_code); end
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_held_valid: got %b expected 0", key_valid); end
    endtask

    // Key 0 held from reset release: accept at edge 12, repeats every 20 edges.
    task automatic test_repeat;
        int strobes;
        int at [8];
        int exp_strobes;
        logic prev_valid;
`ifdef KEYPAD_REPEAT_EN
        exp_strobes = 5;
`else
        exp_strobes = 1;
`endif
        strobes    = 0;
        prev_valid = 1'b0;
        keys = 16'h0001;
        repeat (2) step();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 95; i++) begin
            step();
            n_checks++;
            if (key_valid === 1'b1 && prev_valid === 1'b1) begin
                n_fail++; $display("FAIL valid_back_to_back edge %0d: got 11 expected 10", i);
            end
            if (key_valid === 1'b1) begin
                if (strobes < 8) at[strobes] = i;
                strobes++;
                n_checks++;
                if (key_code !== 4'h0) begin n_fail++; $display("FAIL repeat_code edge %0d: got %h expected 0", i, key_code); end
            end
            prev_valid = key_valid;
        end
        n_checks++;
        if (strobes != exp_strobes) begin n_fail++; $display("FAIL repeat_count: got %0d expected %0d", strobes, exp_strobes); end
        for (int k = 0; k < strobes && k < 8; k++) begin
            n_checks++;
            if (at[k] != 12 + 20 * k) begin n_fail++; $display("FAIL repeat_edge %0d: got %0d expected %0d", k, at[k], 12 + 20 * k); end
        end
        n_checks++;
        if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL repeat_pressed: got %b expected 1", key_pressed); end
        keys = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_scan();
        test_press();
        test_glitch();
        test_multi_row();
        test_reset_in_held();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
